// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared opcode/funct constants, ALU operation encoding and
// the packed control bundle exchanged between the decoders and the output register.
package control_unit_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encoding seen by the datapath
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SLL = 4'b1000,
    ALU_SRL = 4'b1001,
    ALU_LUI = 4'b1010,
    ALU_NOR = 4'b1100
  } alu_op_e;

  // Full set of datapath controls produced for one instruction
  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    branch;
    logic    mem_write;
    logic    mem_to_reg;
    logic    jump;
    logic    jal;
    logic    jr;
    alu_op_e alu_ctrl;
    logic    illegal;
  } ctrl_t;

  // Quiet bundle: every strobe off, ALU parked on ADD
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_ADD;
    return c;
  endfunction

  // Bundle for an undecodable instruction
  function automatic ctrl_t ctrl_illegal();
    ctrl_t c;
    c         = ctrl_default();
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// alu_decoder: combinational opcode/funct -> ALU operation, plus R-type legality
// and jr detection. Extended ops (xor, nor, sll, srl, lui) are decoded only when
// CONTROL_UNIT_EXT_OPS_EN is defined; otherwise they fall back to ADD / not legal.
module alu_decoder
  import control_unit_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_rtype_legal,
  output logic       o_rtype_jr
);

  alu_op_e w_alu;
  logic    w_rlegal;
  logic    w_jr;

  // Select the ALU operation; anything unrecognised parks on ADD
  always_comb begin
    w_alu    = ALU_ADD;
    w_rlegal = 1'b0;
    w_jr     = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD: begin w_alu = ALU_ADD; w_rlegal = 1'b1; end
          FN_SUB: begin w_alu = ALU_SUB; w_rlegal = 1'b1; end
          FN_AND: begin w_alu = ALU_AND; w_rlegal = 1'b1; end
          FN_OR:  begin w_alu = ALU_OR;  w_rlegal = 1'b1; end
          FN_SLT: begin w_alu = ALU_SLT; w_rlegal = 1'b1; end
          FN_JR:  begin w_alu = ALU_ADD; w_rlegal = 1'b1; w_jr = 1'b1; end
`ifdef CONTROL_UNIT_EXT_OPS_EN
          FN_XOR: begin w_alu = ALU_XOR; w_rlegal = 1'b1; end
          FN_NOR: begin w_alu = ALU_NOR; w_rlegal = 1'b1; end
          FN_SLL: begin w_alu = ALU_SLL; w_rlegal = 1'b1; end
          FN_SRL: begin w_alu = ALU_SRL; w_rlegal = 1'b1; end
`else
          // Extended R-type ops are not built in: treat as undecodable
          FN_XOR, FN_NOR, FN_SLL, FN_SRL: begin w_alu = ALU_ADD; w_rlegal = 1'b0; end
`endif
          default: begin w_alu = ALU_ADD; w_rlegal = 1'b0; end
        endcase
      end
      OP_ANDI: w_alu = ALU_AND;
      OP_ORI:  w_alu = ALU_OR;
      OP_SLTI: w_alu = ALU_SLT;
      OP_BEQ:  w_alu = ALU_SUB;
`ifdef CONTROL_UNIT_EXT_OPS_EN
      OP_LUI:  w_alu = ALU_LUI;
`else
      OP_LUI:  w_alu = ALU_ADD;
`endif
      // addi, lw, sw, j, jal and unknown opcodes all use ADD
      default: w_alu = ALU_ADD;
    endcase
  end

  assign o_alu_ctrl    = w_alu;
  assign o_rtype_legal = w_rlegal;
  assign o_rtype_jr    = w_jr;

endmodule

// File: rtl/control_unit.sv
// control_unit: main instruction decoder with a single registered output stage
// (one-cycle latency). Optional macro CONTROL_UNIT_EXT_OPS_EN enables the
// extended ops (xor, nor, sll, srl, lui); without it they decode as illegal.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       regWrite,
  output logic       regDesination,
  output logic       aluSource,
  output logic       branch,
  output logic       memWrite,
  output logic       memToReg,
  output logic       jump,
  output logic       jal,
  output logic       jr,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  logic [3:0] w_alu_ctrl;
  logic       w_rtype_legal;
  logic       w_rtype_jr;
  ctrl_t      w_ctrl;
  ctrl_t      r_ctrl;

  alu_decoder u_alu_decoder (
    .i_opcode      (opcode),
    .i_funct       (funct),
    .o_alu_ctrl    (w_alu_ctrl),
    .o_rtype_legal (w_rtype_legal),
    .o_rtype_jr    (w_rtype_jr)
  );

  // Build the control bundle; illegal encodings collapse to the quiet ADD bundle
  always_comb begin
    w_ctrl          = ctrl_default();
    w_ctrl.alu_ctrl = alu_op_e'(w_alu_ctrl);
    case (opcode)
      OP_RTYPE: begin
        if (!w_rtype_legal) begin
          w_ctrl = ctrl_illegal();
        end else if (w_rtype_jr) begin
          // jr never writes the register file
          w_ctrl.jr = 1'b1;
        end else begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = 1'b1;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
`ifdef CONTROL_UNIT_EXT_OPS_EN
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
`else
      OP_LUI: w_ctrl = ctrl_illegal();
`endif
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ: w_ctrl.branch = 1'b1;
      OP_J:   w_ctrl.jump   = 1'b1;
      OP_JAL: begin
        // Link register is fixed, so rt/rd select stays 0
        w_ctrl.jump      = 1'b1;
        w_ctrl.jal       = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      default: w_ctrl = ctrl_illegal();
    endcase
  end

  // ---- output register stage: reset wins over the decode on the same edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
    end else begin
      r_ctrl <= w_ctrl;
    end
  end

  assign regWrite      = r_ctrl.reg_write;
  assign regDesination = r_ctrl.reg_dst;
  assign aluSource     = r_ctrl.alu_src;
  assign branch        = r_ctrl.branch;
  assign memWrite      = r_ctrl.mem_write;
  assign memToReg      = r_ctrl.mem_to_reg;
  assign jump          = r_ctrl.jump;
  assign jal           = r_ctrl.jal;
  assign jr            = r_ctrl.jr;
  assign alu_ctrl      = r_ctrl.alu_ctrl;
  assign illegal       = r_ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors with hand-computed expected control bundles.
// Bundle order: {regWrite,regDesination,aluSource,branch,memWrite,memToReg,
//                jump,jal,jr,alu_ctrl[3:0],illegal}
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       regWrite, regDesination, aluSource, branch, memWrite, memToReg;
  logic       jump, jal, jr, illegal;
  logic [3:0] alu_ctrl;

  int n_checks;
  int n_pass;

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct         (funct),
    .regWrite      (regWrite),
    .regDesination (regDesination),
    .aluSource     (aluSource),
    .branch        (branch),
    .memWrite      (memWrite),
    .memToReg      (memToReg),
    .jump          (jump),
    .jal           (jal),
    .jr            (jr),
    .alu_ctrl      (alu_ctrl),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bundles, written out by hand
  localparam logic [13:0] E_ZERO  = 14'b0_0_0_0_0_0_0_0_0_0000_0;
  localparam logic [13:0] E_ILL   = 14'b0_0_0_0_0_0_0_0_0_0010_1;
  localparam logic [13:0] E_JAL   = 14'b1_0_0_0_0_0_1_1_0_0010_0;
  localparam logic [13:0] E_J     = 14'b0_0_0_0_0_0_1_0_0_0010_0;
  localparam logic [13:0] E_JR    = 14'b0_0_0_0_0_0_0_0_1_0010_0;
  localparam logic [13:0] E_ADD   = 14'b1_1_0_0_0_0_0_0_0_0010_0;
  localparam logic [13:0] E_SUB   = 14'b1_1_0_0_0_0_0_0_0_0110_0;
  localparam logic [13:0] E_AND   = 14'b1_1_0_0_0_0_0_0_0_0000_0;
  localparam logic [13:0] E_OR    = 14'b1_1_0_0_0_0_0_0_0_0001_0;
  localparam logic [13:0] E_SLT   = 14'b1_1_0_0_0_0_0_0_0_0111_0;
  localparam logic [13:0] E_XOR   = 14'b1_1_0_0_0_0_0_0_0_0011_0;
  localparam logic [13:0] E_NOR   = 14'b1_1_0_0_0_0_0_0_0_1100_0;
  localparam logic [13:0] E_SLL   = 14'b1_1_0_0_0_0_0_0_0_1000_0;
  localparam logic [13:0] E_SRL   = 14'b1_1_0_0_0_0_0_0_0_1001_0;
  localparam logic [13:0] E_ADDI  = 14'b1_0_1_0_0_0_0_0_0_0010_0;
  localparam logic [13:0] E_ANDI  = 14'b1_0_1_0_0_0_0_0_0_0000_0;
  localparam logic [13:0] E_ORI   = 14'b1_0_1_0_0_0_0_0_0_0001_0;
  localparam logic [13:0] E_SLTI  = 14'b1_0_1_0_0_0_0_0_0_0111_0;
  localparam logic [13:0] E_LUI   = 14'b1_0_1_0_0_0_0_0_0_1010_0;
  localparam logic [13:0] E_LW    = 14'b1_0_1_0_0_1_0_0_0_0010_0;
  localparam logic [13:0] E_SW    = 14'b0_0_1_0_1_0_0_0_0_0010_0;
  localparam logic [13:0] E_BEQ   = 14'b0_0_0_1_0_0_0_0_0_0110_0;

  function automatic logic [13:0] observed();
    return {regWrite, regDesination, aluSource, branch, memWrite, memToReg,
            jump, jal, jr, alu_ctrl, illegal};
  endfunction

  // Single comparison point: count it, report any difference
  task automatic chk(input string tag, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", tag, act, exp);
  endtask

  // Present inputs away from the edge, take one edge, sample 1ns after it
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn);
    @(negedge clk);
    rst    = r;
    opcode = op;
    funct  = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic [13:0] exp);
    step(1'b0, op, fn);
    chk(tag, observed(), exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    opcode   = 6'b000011;
    funct    = 6'b000100;

    // Reset with a jal on the inputs
    step(1'b1, 6'b000011, 6'b000100);
    chk("reset_state", observed(), E_ZERO);

    // First edge after reset release decodes the current inputs
    dec("jal_after_reset", 6'b000011, 6'b000100, E_JAL);

    // R-type base set and jr
    dec("r_slt", 6'b000000, 6'b101010, E_SLT);
    dec("r_jr",  6'b000000, 6'b001000, E_JR);
    dec("r_add", 6'b000000, 6'b100000, E_ADD);
    dec("r_sub", 6'b000000, 6'b100010, E_SUB);
    dec("r_and", 6'b000000, 6'b100100, E_AND);
    dec("r_or",  6'b000000, 6'b100101, E_OR);

    // Memory, branch, jump
    dec("lw",  6'b100011, 6'b000000, E_LW);
    dec("sw",  6'b101011, 6'b111111, E_SW);
    dec("beq", 6'b000100, 6'b000000, E_BEQ);
    dec("j",   6'b000010, 6'b101010, E_J);

    // I-type base set; funct must be ignored
    dec("addi",       6'b001000, 6'b000000, E_ADDI);
    dec("addi_fnign", 6'b001000, 6'b101010, E_ADDI);
    dec("andi",       6'b001100, 6'b001000, E_ANDI);
    dec("ori",        6'b001101, 6'b000000, E_ORI);
    dec("slti",       6'b001010, 6'b100100, E_SLTI);

    // Extended set, build-dependent
`ifdef CONTROL_UNIT_EXT_OPS_EN
    dec("lui",   6'b001111, 6'b000000, E_LUI);
    dec("r_xor", 6'b000000, 6'b100110, E_XOR);
    dec("r_nor", 6'b000000, 6'b100111, E_NOR);
    dec("r_sll", 6'b000000, 6'b000000, E_SLL);
    dec("r_srl", 6'b000000, 6'b000010, E_SRL);
`else
    dec("lui",   6'b001111, 6'b000000, E_ILL);
    dec("r_xor", 6'b000000, 6'b100110, E_ILL);
    dec("r_nor", 6'b000000, 6'b100111, E_ILL);
    dec("r_sll", 6'b000000, 6'b000000, E_ILL);
    dec("r_srl", 6'b000000, 6'b000010, E_ILL);
`endif

    // Illegal encodings
    dec("ill_op",    6'b111111, 6'b000000, E_ILL);
    dec("ill_funct", 6'b000000, 6'b111111, E_ILL);
    dec("ill_op2",   6'b000001, 6'b100000, E_ILL);

    // Reset asserted mid-stream during a jal decode
    dec("jal_pre_rst", 6'b000011, 6'b000000, E_JAL);
    step(1'b1, 6'b000011, 6'b000000);
    chk("rst_midstream", observed(), E_ZERO);
    dec("rst_release", 6'b101011, 6'b000000, E_SW);

    // Inputs change between edges: outputs hold until the next rising edge
    dec("hold_setup", 6'b000100, 6'b000000, E_BEQ);
    @(negedge clk);
    opcode = 6'b100011;
    funct  = 6'b000000;
    #2;
    chk("hold_between_edges", observed(), E_BEQ);
    @(posedge clk);
    #1;
    chk("hold_next_edge", observed(), E_LW);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
